id_stage: RTL and testbench

Instruction decode stage of the five-stage pipeline. It sits directly downstream of the fetch stage and consumes the fetch stage's valid/ready handshake together with `PC_IF`, `IR_IF` and `imem_axi_rresp_IF`. Each instruction is decoded to RV32I control fields, its immediate is generated, and operands are read from the integer register file, which lives here and is written from writeback. Results are held in an ID/EX pipeline register that uses the same valid/ready/flush protocol as fetch.

---
 rtl/CPU_pkg.sv | 83 ++++++++
 rtl/reg_file.sv | 33 +++
 rtl/id_stage.sv | 196 +++++++++++++++++++
 tb/tb_id_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/CPU_pkg.sv
// rtl/CPU_pkg.sv - shared RV32I constants, decode enums and the ID/EX register layout
package CPU_pkg;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    OP_NONE    = 4'd0,
    OP_ALU     = 4'd1,
    OP_ALU_IMM = 4'd2,
    OP_LOAD    = 4'd3,
    OP_STORE   = 4'd4,
    OP_BRANCH  = 4'd5,
    OP_JAL     = 4'd6,
    OP_JALR    = 4'd7,
    OP_LUI     = 4'd8,
    OP_AUIPC   = 4'd9,
    OP_FENCE   = 4'd10,
    OP_SYSTEM  = 4'd11
  } op_class_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    op_class_t   op_class;
    alu_op_t     alu_op;
    logic [2:0]  funct3;
    logic        rd_we;
    logic        illegal;
    logic [1:0]  rresp;
  } id_ex_t;

  // alt selects SUB/SRA; callers decide when instr[30] is meaningful
  function automatic alu_op_t alu_op_from(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 integer register file, 2 async reads, 1 sync write, write-first bypass
module reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);

  logic [31:0] regs [0:31];
  logic        wr_live;

  assign wr_live = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (wr_live) regs[waddr] <= wdata;
  end

  // x0 is never written, so its storage is ignored and reads force zero
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == 5'd0)                  rdata1 = '0;
    else if (wr_live && waddr == raddr1) rdata1 = wdata;

    rdata2 = regs[raddr2];
    if (raddr2 == 5'd0)                  rdata2 = '0;
    else if (wr_live && waddr == raddr2) rdata2 = wdata;
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: decoder, immediate generator, register file and ID/EX register
module id_stage
  import CPU_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] PC_IF,
  input  logic [31:0] IR_IF,
  input  logic [1:0]  imem_axi_rresp_IF,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic        rd_we_WB,
  input  logic [4:0]  rd_addr_WB,
  input  logic [31:0] rd_data_WB,
  output logic [31:0] PC_ID,
  output logic [31:0] IR_ID,
  output logic [4:0]  rs1_addr_ID,
  output logic [4:0]  rs2_addr_ID,
  output logic [4:0]  rd_addr_ID,
  output logic [31:0] rs1_data_ID,
  output logic [31:0] rs2_data_ID,
  output logic [31:0] imm_ID,
  output logic [3:0]  op_class_ID,
  output logic [3:0]  alu_op_ID,
  output logic [2:0]  funct3_ID,
  output logic        rd_we_ID,
  output logic        illegal_inst_ID,
  output logic [1:0]  imem_axi_rresp_ID
);

  logic        valid_reg;
  logic        load;
  id_ex_t      id_ex;
  id_ex_t      next_entry;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  op_class_t   dec_class;
  alu_op_t     dec_alu;
  logic [31:0] dec_imm;
  logic        use_rs1, use_rs2, use_rd, dec_illegal;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] rs1_rdata, rs2_rdata;

  assign opcode = IR_IF[6:0];
  assign funct3 = IR_IF[14:12];
  assign funct7 = IR_IF[31:25];

  assign imm_i = {{20{IR_IF[31]}}, IR_IF[31:20]};
  assign imm_s = {{20{IR_IF[31]}}, IR_IF[31:25], IR_IF[11:7]};
  assign imm_b = {{19{IR_IF[31]}}, IR_IF[31], IR_IF[7], IR_IF[30:25], IR_IF[11:8], 1'b0};
  assign imm_u = {IR_IF[31:12], 12'b0};
  assign imm_j = {{11{IR_IF[31]}}, IR_IF[31], IR_IF[19:12], IR_IF[20], IR_IF[30:21], 1'b0};

  always_comb begin
    dec_class   = OP_NONE;
    dec_alu     = ALU_ADD;
    dec_imm     = '0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    use_rd      = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPCODE_LUI:   begin dec_class = OP_LUI;   dec_imm = imm_u; use_rd = 1'b1; end
      OPCODE_AUIPC: begin dec_class = OP_AUIPC; dec_imm = imm_u; use_rd = 1'b1; end
      OPCODE_JAL:   begin dec_class = OP_JAL;   dec_imm = imm_j; use_rd = 1'b1; end
      OPCODE_JALR: begin
        dec_class = OP_JALR; dec_imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
        dec_illegal = (funct3 != 3'b000);
      end
      OPCODE_BRANCH: begin
        dec_class = OP_BRANCH; dec_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPCODE_LOAD: begin
        dec_class = OP_LOAD; dec_imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
        dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPCODE_STORE: begin
        dec_class = OP_STORE; dec_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec_illegal = (funct3 > 3'b010);
      end
      OPCODE_OP_IMM: begin
        dec_class = OP_ALU_IMM; dec_imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
        dec_alu   = alu_op_from(funct3, (funct3 == 3'b101) && IR_IF[30]);
        // shift-immediates reuse imm[11:5] as a funct7 field
        if (funct3 == 3'b001)
          dec_illegal = (funct7 != FUNCT7_BASE);
        else if (funct3 == 3'b101)
          dec_illegal = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
      end
      OPCODE_OP: begin
        dec_class = OP_ALU; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        dec_alu   = alu_op_from(funct3, IR_IF[30]);
        dec_illegal = !((funct7 == FUNCT7_BASE) ||
                        ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPCODE_MISC_MEM: begin
        dec_class = OP_FENCE; dec_imm = imm_i;
        dec_illegal = (funct3 != 3'b000);
      end
      OPCODE_SYSTEM: begin
        dec_class = OP_SYSTEM; dec_imm = imm_i;
        dec_illegal = (funct3 != 3'b000);
      end
      default: dec_illegal = 1'b1;
    endcase
    if (IR_IF[1:0] != 2'b11) dec_illegal = 1'b1;
    if (dec_illegal) begin
      dec_class = OP_NONE;
      dec_alu   = ALU_ADD;
      dec_imm   = '0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      use_rd    = 1'b0;
    end
  end

  assign dec_rs1 = use_rs1 ? IR_IF[19:15] : 5'd0;
  assign dec_rs2 = use_rs2 ? IR_IF[24:20] : 5'd0;
  assign dec_rd  = use_rd  ? IR_IF[11:7]  : 5'd0;

  reg_file u_reg_file (
    .clk    (clk),
    .we     (rd_we_WB),
    .waddr  (rd_addr_WB),
    .wdata  (rd_data_WB),
    .raddr1 (dec_rs1),
    .rdata1 (rs1_rdata),
    .raddr2 (dec_rs2),
    .rdata2 (rs2_rdata)
  );

  always_comb begin
    next_entry          = '0;
    next_entry.pc       = PC_IF;
    next_entry.ir       = IR_IF;
    next_entry.rs1_addr = dec_rs1;
    next_entry.rs2_addr = dec_rs2;
    next_entry.rd_addr  = dec_rd;
    next_entry.rs1_data = rs1_rdata;
    next_entry.rs2_data = rs2_rdata;
    next_entry.imm      = dec_imm;
    next_entry.op_class = dec_class;
    next_entry.alu_op   = dec_alu;
    next_entry.funct3   = funct3;
    next_entry.rd_we    = use_rd && (dec_rd != 5'd0);
    next_entry.illegal  = dec_illegal;
    next_entry.rresp    = imem_axi_rresp_IF;
  end

  assign ready_out = !valid_reg || ready_in;
  assign load      = valid_in && ready_out && !flush;
  assign valid_out = valid_reg && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      id_ex     <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      id_ex     <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      id_ex     <= next_entry;
    end else if (valid_reg && ready_in) begin
      valid_reg <= 1'b0;
    end else if (valid_reg && rd_we_WB && (rd_addr_WB != 5'd0)) begin
      // stalled: keep held operands coherent with writeback
      if (rd_addr_WB == id_ex.rs1_addr) id_ex.rs1_data <= rd_data_WB;
      if (rd_addr_WB == id_ex.rs2_addr) id_ex.rs2_data <= rd_data_WB;
    end
  end

  assign PC_ID             = id_ex.pc;
  assign IR_ID             = id_ex.ir;
  assign rs1_addr_ID       = id_ex.rs1_addr;
  assign rs2_addr_ID       = id_ex.rs2_addr;
  assign rd_addr_ID        = id_ex.rd_addr;
  assign rs1_data_ID       = id_ex.rs1_data;
  assign rs2_data_ID       = id_ex.rs2_data;
  assign imm_ID            = id_ex.imm;
  assign op_class_ID       = id_ex.op_class;
  assign alu_op_ID         = id_ex.alu_op;
  assign funct3_ID         = id_ex.funct3;
  assign rd_we_ID          = id_ex.rd_we;
  assign illegal_inst_ID   = id_ex.illegal;
  assign imem_axi_rresp_ID = id_ex.rresp;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized bench for id_stage against an instruction-level reference model
module tb_id_stage;
  import CPU_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, valid_in, ready_in, rd_we_WB;
  logic [31:0] PC_IF, IR_IF, rd_data_WB;
  logic [1:0]  imem_axi_rresp_IF;
  logic [4:0]  rd_addr_WB;
  logic        ready_out, valid_out, rd_we_ID, illegal_inst_ID;
  logic [31:0] PC_ID, IR_ID, rs1_data_ID, rs2_data_ID, imm_ID;
  logic [4:0]  rs1_addr_ID, rs2_addr_ID, rd_addr_ID;
  logic [3:0]  op_class_ID, alu_op_ID;
  logic [2:0]  funct3_ID;
  logic [1:0]  imem_axi_rresp_ID;

  id_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
    .PC_IF(PC_IF), .IR_IF(IR_IF), .imem_axi_rresp_IF(imem_axi_rresp_IF),
    .valid_out(valid_out), .ready_in(ready_in),
    .rd_we_WB(rd_we_WB), .rd_addr_WB(rd_addr_WB), .rd_data_WB(rd_data_WB),
    .PC_ID(PC_ID), .IR_ID(IR_ID), .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
    .rd_addr_ID(rd_addr_ID), .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
    .imm_ID(imm_ID), .op_class_ID(op_class_ID), .alu_op_ID(alu_op_ID), .funct3_ID(funct3_ID),
    .rd_we_ID(rd_we_ID), .illegal_inst_ID(illegal_inst_ID), .imem_axi_rresp_ID(imem_axi_rresp_ID)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, ir, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rda;
    logic [3:0]  cls, alu;
    logic [2:0]  f3;
    logic        rdwe, ill;
    logic [1:0]  rresp;
  } exp_t;

  exp_t        m_out;
  logic        m_valid;
  logic [31:0] m_regs [32];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Instruction-level view: which fields an opcode uses, which funct values exist, offset arithmetic
  function automatic exp_t ref_decode(input logic [31:0] ir, input logic [31:0] pc, input logic [1:0] rresp);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok, u1, u2, ud;
    int   off;
    e = '{default: 0};
    f3 = ir[14:12]; f7 = ir[31:25];
    ok = 1; u1 = 0; u2 = 0; ud = 0;
    case (ir[6:0])
      7'h37: begin e.cls = OP_LUI;   ud = 1; e.imm = ir & 32'hFFFF_F000; end
      7'h17: begin e.cls = OP_AUIPC; ud = 1; e.imm = ir & 32'hFFFF_F000; end
      7'h6F: begin e.cls = OP_JAL; ud = 1;
        off = $signed({ir[31], ir[19:12], ir[20], ir[30:21]}); e.imm = off * 2; end
      7'h67: begin e.cls = OP_JALR; u1 = 1; ud = 1; ok = (f3 == 0);
        off = $signed(ir[31:20]); e.imm = off; end
      7'h63: begin e.cls = OP_BRANCH; u1 = 1; u2 = 1; ok = !(f3 == 2 || f3 == 3);
        off = $signed({ir[31], ir[7], ir[30:25], ir[11:8]}); e.imm = off * 2; end
      7'h03: begin e.cls = OP_LOAD; u1 = 1; ud = 1; ok = (f3 inside {0, 1, 2, 4, 5});
        off = $signed(ir[31:20]); e.imm = off; end
      7'h23: begin e.cls = OP_STORE; u1 = 1; u2 = 1; ok = (f3 <= 2);
        off = $signed({ir[31:25], ir[11:7]}); e.imm = off; end
      7'h13: begin e.cls = OP_ALU_IMM; u1 = 1; ud = 1;
        off = $signed(ir[31:20]); e.imm = off;
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        e.alu = ref_alu(f3, f3 == 5 && f7 == 7'h20); end
      7'h33: begin e.cls = OP_ALU; u1 = 1; u2 = 1; ud = 1;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.alu = ref_alu(f3, f7 == 7'h20); end
      7'h0F: begin e.cls = OP_FENCE;  ok = (f3 == 0); off = $signed(ir[31:20]); e.imm = off; end
      7'h73: begin e.cls = OP_SYSTEM; ok = (f3 == 0); off = $signed(ir[31:20]); e.imm = off; end
      default: ok = 0;
    endcase
    if (ir[1:0] != 2'b11) ok = 0;
    if (!ok) begin
      e.cls = OP_NONE; e.alu = ALU_ADD; e.imm = 0; u1 = 0; u2 = 0; ud = 0;
    end
    e.ill  = !ok;
    e.rs1a = u1 ? ir[19:15] : 5'd0;
    e.rs2a = u2 ? ir[24:20] : 5'd0;
    e.rda  = ud ? ir[11:7]  : 5'd0;
    e.rdwe = ud && (ir[11:7] != 0);
    e.pc = pc; e.ir = ir; e.f3 = f3; e.rresp = rresp;
    return e;
  endfunction

  task automatic compare_outputs();
    check("valid_out", valid_out, m_valid && !flush);
    check("ready_out", ready_out, !m_valid || ready_in);
    check("PC_ID", PC_ID, m_out.pc);
    check("IR_ID", IR_ID, m_out.ir);
    check("rs1_addr_ID", rs1_addr_ID, m_out.rs1a);
    check("rs2_addr_ID", rs2_addr_ID, m_out.rs2a);
    check("rd_addr_ID", rd_addr_ID, m_out.rda);
    check("rs1_data_ID", rs1_data_ID, m_out.rs1d);
    check("rs2_data_ID", rs2_data_ID, m_out.rs2d);
    check("imm_ID", imm_ID, m_out.imm);
    check("op_class_ID", op_class_ID, m_out.cls);
    check("alu_op_ID", alu_op_ID, m_out.alu);
    check("funct3_ID", funct3_ID, m_out.f3);
    check("rd_we_ID", rd_we_ID, m_out.rdwe);
    check("illegal_inst_ID", illegal_inst_ID, m_out.ill);
    check("rresp_ID", imem_axi_rresp_ID, m_out.rresp);
  endtask

  // Compare mid-cycle, then advance the model across the rising edge using the inputs that were applied
  task automatic cycle();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    if (rd_we_WB && rd_addr_WB != 0) m_regs[rd_addr_WB] = rd_data_WB;
    if (flush) begin
      m_valid = 0; m_out = '{default: 0};
    end else if (valid_in && (!m_valid || ready_in)) begin
      m_out = ref_decode(IR_IF, PC_IF, imem_axi_rresp_IF);
      m_out.rs1d = m_regs[m_out.rs1a];
      m_out.rs2d = m_regs[m_out.rs2a];
      m_valid = 1;
    end else if (m_valid && ready_in) begin
      m_valid = 0;
    end else if (m_valid) begin
      m_out.rs1d = m_regs[m_out.rs1a];
      m_out.rs2d = m_regs[m_out.rs2a];
    end
    #1;
  endtask

  task automatic offer(input logic [31:0] ir, input logic [31:0] pc);
    valid_in = 1; IR_IF = ir; PC_IF = pc; imem_axi_rresp_IF = 2'b00;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0]  ops [11];
    logic [31:0] ir;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    ir = $urandom;
    if ($urandom_range(0, 9) != 0) begin
      ir[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: ir[31:25] = 7'h00;
        1: ir[31:25] = 7'h20;
        default: ;
      endcase
    end
    return ir;
  endfunction

  logic [31:0] b2b_ir  [4];
  logic [31:0] b2b_imm [4];

  initial begin
    reset = 1; flush = 0; valid_in = 0; ready_in = 1; rd_we_WB = 0;
    rd_addr_WB = 0; rd_data_WB = 0; PC_IF = 0; IR_IF = 0; imem_axi_rresp_IF = 0;
    m_valid = 0; m_out = '{default: 0};
    for (int i = 0; i < 32; i++) m_regs[i] = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready_out", ready_out, 1);
    check("reset_valid_out", valid_out, 0);
    compare_outputs();
    reset = 0;

    // Fill the register file so every later read has a known value
    for (int r = 1; r < 32; r++) begin
      rd_we_WB = 1; rd_addr_WB = r[4:0];
      rd_data_WB = (r == 5) ? 32'h0000_1234 : $urandom;
      cycle();
    end
    rd_we_WB = 0;

    offer(32'hFFF2_8313, 32'h0000_0100);
    cycle();
    valid_in = 0;
    check("addi_valid", valid_out, 1);
    check("addi_rs1_data", rs1_data_ID, 32'h0000_1234);
    check("addi_imm", imm_ID, 32'hFFFF_FFFF);
    check("addi_class", op_class_ID, OP_ALU_IMM);
    check("addi_alu", alu_op_ID, ALU_ADD);
    check("addi_rd", rd_addr_ID, 6);

    b2b_ir  = '{32'h0020_8463, 32'h0020_A623, 32'hFFDF_F0EF, 32'h1234_51B7};
    b2b_imm = '{32'h0000_0008, 32'h0000_000C, 32'hFFFF_FFFC, 32'h1234_5000};
    for (int k = 0; k < 4; k++) begin
      offer(b2b_ir[k], 32'h200 + 4 * k);
      cycle();
      check("b2b_valid", valid_out, 1);
      check("b2b_imm", imm_ID, b2b_imm[k]);
    end
    valid_in = 0;
    cycle();

    // Stall with a held beq, then write its rs2 (x2) from writeback
    offer(32'h0020_8463, 32'h300);
    cycle();
    ready_in = 0;
    offer(32'h0050_0093, 32'h304);
    rd_we_WB = 1; rd_addr_WB = 2; rd_data_WB = 32'hCAFE_F00D;
    cycle();
    rd_we_WB = 0;
    check("stall_ready_out", ready_out, 0);
    check("stall_rs2_refresh", rs2_data_ID, 32'hCAFE_F00D);
    check("stall_ir_held", IR_ID, 32'h0020_8463);
    cycle();
    ready_in = 1;
    cycle();
    valid_in = 0;
    cycle();

    // Flush with one held and one offered
    ready_in = 0;
    offer(32'h0020_81B3, 32'h400);
    cycle();
    offer(32'h0050_0093, 32'h404);
    flush = 1;
    #1;
    check("flush_valid_same_cycle", valid_out, 0);
    cycle();
    flush = 0; valid_in = 0;
    check("flush_valid_after", valid_out, 0);
    check("flush_ir_zero", IR_ID, 0);
    check("flush_pc_zero", PC_ID, 0);
    cycle();
    ready_in = 1;

    offer(32'h0000_0000, 32'h500);
    cycle();
    check("ill_zero_flag", illegal_inst_ID, 1);
    check("ill_zero_class", op_class_ID, OP_NONE);
    check("ill_zero_rdwe", rd_we_ID, 0);
    offer(32'h4000_1033, 32'h504);
    cycle();
    check("ill_sll_flag", illegal_inst_ID, 1);
    check("ill_sll_class", op_class_ID, OP_NONE);
    check("ill_sll_rdwe", rd_we_ID, 0);
    check("ill_sll_ir", IR_ID, 32'h4000_1033);

    offer(RV32I_NOP, 32'h600);
    imem_axi_rresp_IF = 2'b10;
    cycle();
    check("rresp_pass", imem_axi_rresp_ID, 2'b10);
    check("rresp_not_illegal", illegal_inst_ID, 0);

    offer(32'h0050_0093, 32'h700);
    rd_we_WB = 1; rd_addr_WB = 0; rd_data_WB = 32'hFFFF_FFFF;
    cycle();
    rd_we_WB = 0;
    offer(32'h0000_01B3, 32'h704);
    cycle();
    check("x0_rs1_zero", rs1_data_ID, 0);
    check("x0_rs2_zero", rs2_data_ID, 0);

    offer(32'h0094_8533, 32'h800);
    rd_we_WB = 1; rd_addr_WB = 9; rd_data_WB = 32'h5A5A_0001;
    cycle();
    rd_we_WB = 0;
    check("bypass_rs1", rs1_data_ID, 32'h5A5A_0001);
    check("bypass_rs2", rs2_data_ID, 32'h5A5A_0001);

    // Reset during a stall drops the held instruction at once
    ready_in = 0;
    offer(RV32I_NOP, 32'h900);
    cycle();
    valid_in = 0;
    reset = 1;
    #1;
    check("midreset_valid", valid_out, 0);
    check("midreset_ready", ready_out, 1);
    check("midreset_pc", PC_ID, 0);
    @(posedge clk);
    #1;
    reset = 0;
    m_valid = 0; m_out = '{default: 0};
    ready_in = 1;
    cycle();

    for (int n = 0; n < 1500; n++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      PC_IF    = $urandom & 32'hFFFF_FFFC;
      IR_IF    = rand_ir();
      imem_axi_rresp_IF = 2'b00;
      if ($urandom_range(0, 9) == 0) begin
        IR_IF = RV32I_NOP;
        imem_axi_rresp_IF = $urandom_range(1, 3);
      end
      rd_we_WB   = $urandom_range(0, 1);
      rd_data_WB = $urandom;
      case ($urandom_range(0, 3))
        0:       rd_addr_WB = m_out.rs1a;
        1:       rd_addr_WB = m_out.rs2a;
        default: rd_addr_WB = $urandom_range(0, 31);
      endcase
      cycle();
    end

    valid_in = 0; flush = 0; rd_we_WB = 0; ready_in = 1;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
